vga_capture: RTL and testbench
==============================

// Module: vga_capture
// PURPOSE
// Receive-side counterpart of the VGA display path: samples an incoming pclk-synchronous VGA stream
// (hor_sync, ver_sync, 4:4:4 RGB), reconstructs pixel/line position from the sync edges, and writes one
// rectangular window of one frame into a frame-buffer RAM, row-major, 12-bit {r,g,b} per word.
// Single-shot: armed by cap_start, captures the next complete frame, pulses frame_done.
// PARAMETERS
// H_START   144   pclks from hsync leading edge to first active pixel (sync 96 + back porch 48)
// H_TOTAL   800   pclks per line; hsync leading-edge spacing checked against this
// V_START   35    lines from vsync leading edge to first active line (sync 2 + back porch 33)
// CAP_X     0     window left offset within active area, pixels
// CAP_Y     0     window top offset within active area, lines
// CAP_W     640   window width, pixels (CAP_X+CAP_W <= active width)
// CAP_H     480   window height, lines
// SYNC_POL  0     sync assertion level (0 = active-low, 1 = active-high)
// ADDR_W    22    wr_addr width
// PORTS
// clk        in   1       pixel clock (25 MHz), same domain as incoming stream
// rst_n      in   1       reset, synchronous, active-low
// hor_sync   in   1       incoming horizontal sync
// ver_sync   in   1       incoming vertical sync
// vga_r      in   4       incoming red
// vga_g      in   4       incoming green
// vga_b      in   4       incoming blue
// cap_start  in   1       1-cycle request: arm capture of next full frame
// busy       out  1       high in ARMED or CAPTURE
// wr_en      out  1       frame-buffer write strobe
// wr_addr    out  ADDR_W  frame-buffer word address
// wr_data    out  12      {r,g,b} pixel
// frame_done out  1       1-cycle pulse: window fully written, no error
// frame_err  out  1       sticky: line-length error or early vsync during CAPTURE; cleared by cap_start
// BEHAVIOUR
// - All inputs registered once (stage S1); sync edge = S1 asserted (per SYNC_POL) and previous S1 not.
// - hcnt (11b): 0 in cycle after hsync edge, +1 per clk, saturates 2047. vcnt (11b): 0 after vsync edge
//   (priority over hsync), else +1 on each hsync edge, saturates 2047.
// - In-window: H_START+CAP_X <= hcnt <= H_START+CAP_X+CAP_W-1 and V_START+CAP_Y <= vcnt <= V_START+CAP_Y+CAP_H-1.
// - FSM IDLE -> ARMED on cap_start (clears frame_err). ARMED -> CAPTURE on vsync edge. CAPTURE -> DONE after
//   write of address CAP_W*CAP_H-1. DONE -> IDLE next cycle, frame_done=1 for that one cycle.
// - CAPTURE errors: hsync edge spacing != H_TOTAL (first edge after vsync exempt), or vsync edge before window
//   complete -> frame_err=1, state -> IDLE, no frame_done. Partial writes already issued are not undone.
// - cap_start while busy: ignored. cap_start in DONE cycle: ignored.
// - Writes only in CAPTURE and in-window: wr_en=1, wr_data = S1 RGB, wr_addr = 0 for first pixel of frame,
//   +1 per write, never wraps within a frame (max CAP_W*CAP_H-1). Outputs registered.
// - Latency: pixel on input pins in cycle t -> wr_en/wr_data valid in cycle t+2.
// - Reset values: busy=0, wr_en=0, wr_addr=0, wr_data=0, frame_done=0, frame_err=0, state IDLE, hcnt=vcnt=0.
//   Reset mid-capture: wr_en low from first reset edge; no frame_done; restart requires new cap_start.
// TESTING
// 1. 640x480@60 generator, defaults, cap_start mid-frame -> wait for vsync; 307200 writes, addr 0..307199,
//    wr_data matches pattern pixel (x^y), frame_done once, 2 cycles after last pixel.
// 2. CAP_X=10,CAP_Y=5,CAP_W=4,CAP_H=2 -> 8 writes, addr 0..7, first at vcnt=40 hcnt=154; frame_done after 8th.
// 3. One line shortened to 799 pclks inside capture -> frame_err=1, busy=0, frame_done never asserts.
// 4. cap_start pulsed again during CAPTURE -> ignored, write count and addresses identical to scenario 1.
// 5. rst_n low for 1 cycle at write 1000 -> wr_en 0 next cycle, wr_addr=0; no writes until new cap_start+vsync.
// 6. SYNC_POL=1 with inverted syncs -> results identical to scenario 2.

Source files
------------

// File: rtl/vga_capture.sv
// Receive-side VGA frame grabber: rebuilds pixel/line position from the incoming sync edges
// and writes one rectangular window of a single frame, row-major, into a frame-buffer RAM.
module vga_capture #(
    parameter int unsigned H_START  = 144,
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned V_START  = 35,
    parameter int unsigned CAP_X    = 0,
    parameter int unsigned CAP_Y    = 0,
    parameter int unsigned CAP_W    = 640,
    parameter int unsigned CAP_H    = 480,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned ADDR_W   = 22
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hor_sync,
    input  logic              ver_sync,
    input  logic [3:0]        vga_r,
    input  logic [3:0]        vga_g,
    input  logic [3:0]        vga_b,
    input  logic              cap_start,
    output logic              busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int unsigned       N_PIX     = CAP_W * CAP_H;
    localparam logic [10:0]       CNT_MAX   = 11'h7FF;
    localparam logic [10:0]       H_LO      = 11'(H_START + CAP_X);
    localparam logic [10:0]       H_HI      = 11'(H_START + CAP_X + CAP_W - 1);
    localparam logic [10:0]       V_LO      = 11'(V_START + CAP_Y);
    localparam logic [10:0]       V_HI      = 11'(V_START + CAP_Y + CAP_H - 1);
    localparam logic [10:0]       H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_PIX - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic              SYNC_IDLE = ~SYNC_POL;

    // input stage S1 plus the previous S1 sync levels for edge detection
    logic        hs_q, vs_q, hs_prev_q, vs_prev_q, start_q;
    logic [11:0] rgb_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_q      <= SYNC_IDLE;
            vs_q      <= SYNC_IDLE;
            hs_prev_q <= SYNC_IDLE;
            vs_prev_q <= SYNC_IDLE;
            start_q   <= 1'b0;
            rgb_q     <= 12'h000;
        end else begin
            hs_q      <= hor_sync;
            vs_q      <= ver_sync;
            hs_prev_q <= hs_q;
            vs_prev_q <= vs_q;
            start_q   <= cap_start;
            rgb_q     <= {vga_r, vga_g, vga_b};
        end
    end

    logic hs_edge, vs_edge;
    assign hs_edge = (hs_q == SYNC_POL) && (hs_prev_q != SYNC_POL);
    assign vs_edge = (vs_q == SYNC_POL) && (vs_prev_q != SYNC_POL);

    // hcnt_d/vcnt_d are the position of the pixel currently in S1; the registered
    // copies therefore show the position of the pixel written in the same cycle.
    logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;

    always_comb begin
        hcnt_d = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + 11'd1;
        vcnt_d = vcnt_q;
        if (hs_edge) begin
            hcnt_d = 11'd0;
            vcnt_d = (vcnt_q == CNT_MAX) ? CNT_MAX : vcnt_q + 11'd1;
        end
        if (vs_edge) begin
            vcnt_d = 11'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcnt_q <= 11'd0;
            vcnt_q <= 11'd0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    logic in_win;
    assign in_win = (hcnt_d >= H_LO) && (hcnt_d <= H_HI) &&
                    (vcnt_d >= V_LO) && (vcnt_d <= V_HI);

    // state   | meaning
    // IDLE    | waiting for cap_start
    // ARMED   | waiting for the vsync edge that opens the next frame
    // CAPTURE | writing in-window pixels, watching line length and early vsync
    // DONE    | last word written, frame_done high for this one cycle
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t            state_q;
    logic              exempt_q;
    logic [ADDR_W-1:0] cnt_q;

    // the first hsync edge after vsync has no valid predecessor to measure against
    logic line_err, cap_err;
    assign line_err = hs_edge && !vs_edge && !exempt_q && (hcnt_q != H_LAST);
    assign cap_err  = vs_edge || line_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            exempt_q   <= 1'b0;
            cnt_q      <= '0;
            busy       <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 12'h000;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            if (vs_edge) begin
                exempt_q <= !hs_edge;
            end else if (hs_edge) begin
                exempt_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_q) begin
                        state_q   <= ST_ARMED;
                        busy      <= 1'b1;
                        frame_err <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (vs_edge) begin
                        state_q <= ST_CAPTURE;
                        cnt_q   <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (cap_err) begin
                        state_q   <= ST_IDLE;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                    end else if (in_win) begin
                        wr_en   <= 1'b1;
                        wr_data <= rgb_q;
                        wr_addr <= cnt_q;
                        cnt_q   <= cnt_q + ADDR_ONE;
                        if (cnt_q == ADDR_LAST) begin
                            state_q    <= ST_DONE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a scaled-down video timing; a second instance with
// SYNC_POL=1 is fed inverted syncs and must behave identically.
module tb_vga_capture;

    localparam int H_TOTAL = 40;
    localparam int HS_W    = 4;
    localparam int H_START = 10;
    localparam int ACT_W   = 24;
    localparam int V_TOTAL = 12;
    localparam int VS_W    = 2;
    localparam int V_START = 4;
    localparam int ACT_H   = 6;
    localparam int CAP_X   = 3;
    localparam int CAP_Y   = 1;
    localparam int CAP_W   = 5;
    localparam int CAP_H   = 3;
    localparam int N_PIX   = CAP_W * CAP_H;
    localparam int FRAME   = H_TOTAL * V_TOTAL;
    localparam int SHORT_Y = V_START + CAP_Y + 1;
    localparam int ADDR_W  = 8;

    logic clk;
    logic rst_n;
    logic cap_start;
    logic hs_a, vs_a;
    logic [11:0] pix;

    logic [1:0]        busy_w, we_w, done_w, err_w;
    logic [ADDR_W-1:0] addr_w [2];
    logic [11:0]       data_w [2];

    vga_capture #(
        .H_START(H_START), .H_TOTAL(H_TOTAL), .V_START(V_START),
        .CAP_X(CAP_X), .CAP_Y(CAP_Y), .CAP_W(CAP_W), .CAP_H(CAP_H),
        .SYNC_POL(1'b0), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hor_sync(~hs_a), .ver_sync(~vs_a),
        .vga_r(pix[11:8]), .vga_g(pix[7:4]), .vga_b(pix[3:0]), .cap_start(cap_start),
        .busy(busy_w[0]), .wr_en(we_w[0]), .wr_addr(addr_w[0]), .wr_data(data_w[0]),
        .frame_done(done_w[0]), .frame_err(err_w[0])
    );

    vga_capture #(
        .H_START(H_START), .H_TOTAL(H_TOTAL), .V_START(V_START),
        .CAP_X(CAP_X), .CAP_Y(CAP_Y), .CAP_W(CAP_W), .CAP_H(CAP_H),
        .SYNC_POL(1'b1), .ADDR_W(ADDR_W)
    ) dut_p (
        .clk(clk), .rst_n(rst_n), .hor_sync(hs_a), .ver_sync(vs_a),
        .vga_r(pix[11:8]), .vga_g(pix[7:4]), .vga_b(pix[3:0]), .cap_start(cap_start),
        .busy(busy_w[1]), .wr_en(we_w[1]), .wr_addr(addr_w[1]), .wr_data(data_w[1]),
        .frame_done(done_w[1]), .frame_err(err_w[1])
    );

    int total = 0;
    int bad   = 0;
    int gx, gy;
    bit short_en = 1'b0;
    int nw [2];
    int nd [2];
    bit errs [2];
    bit timed_out;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int pat(input int x, input int y);
        return (((x ^ y) & 15) << 8) | ((x & 15) << 4) | (y & 15);
    endfunction

    function automatic int exp_pix(input int k);
        return pat(CAP_X + k % CAP_W, CAP_Y + k / CAP_W);
    endfunction

    task automatic drive_pins();
        hs_a = (gx < HS_W);
        vs_a = (gy < VS_W);
        if (gx >= H_START && gx < H_START + ACT_W && gy >= V_START && gy < V_START + ACT_H)
            pix = 12'(pat(gx - H_START, gy - V_START));
        else
            pix = 12'hFFF;
    endtask

    // free-running video source; pins change on the falling edge
    initial begin
        int len;
        gx = 0;
        gy = 0;
        drive_pins();
        forever begin
            @(negedge clk);
            len = (short_en && gy == SHORT_Y) ? H_TOTAL - 1 : H_TOTAL;
            gx++;
            if (gx >= len) begin
                gx = 0;
                gy = (gy == V_TOTAL - 1) ? 0 : gy + 1;
            end
            drive_pins();
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_line(input int line);
        int n = 0;
        while (!(gy == line && gx == 0) && n < 2 * FRAME) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_line_in_budget", int'(n < 2 * FRAME), 1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        cap_start = 1'b1;
        @(negedge clk);
        cap_start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int max_cyc, input int pulse_at, input int stop_at);
        int cyc = 0;
        int tail = 0;
        int pgx = -100;
        int pgy = -100;
        bit pend = 1'b0;
        bit pulsed = 1'b0;
        for (int i = 0; i < 2; i++) begin
            nw[i] = 0;
            nd[i] = 0;
            errs[i] = 1'b0;
        end
        timed_out = 1'b0;
        forever begin
            @(negedge clk);
            cap_start = pend;
            pend = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (we_w[i]) begin
                    chk($sformatf("wr_addr[%0d]", i), int'(addr_w[i]), nw[i]);
                    chk($sformatf("wr_data[%0d]", i), int'(data_w[i]), exp_pix(nw[i]));
                    chk($sformatf("pix_x[%0d]", i), pgx - H_START, CAP_X + nw[i] % CAP_W);
                    chk($sformatf("pix_y[%0d]", i), pgy - V_START, CAP_Y + nw[i] / CAP_W);
                    nw[i]++;
                end
                if (done_w[i]) begin
                    nd[i]++;
                    chk($sformatf("done_on_last_write[%0d]", i),
                        int'(we_w[i] && int'(addr_w[i]) == N_PIX - 1), 1);
                end
                if (err_w[i]) errs[i] = 1'b1;
            end
            pgx = gx;
            pgy = gy;
            if (pulse_at >= 0 && !pulsed && nw[0] == pulse_at) begin
                pend = 1'b1;
                pulsed = 1'b1;
            end
            if (stop_at >= 0 && nw[0] == stop_at) break;
            if ((nd[0] > 0 || errs[0]) && (nd[1] > 0 || errs[1])) tail++;
            if (tail >= 40) break;
            if (cyc >= max_cyc) begin
                timed_out = 1'b1;
                break;
            end
        end
        cap_start = 1'b0;
    endtask

    task automatic check_clean_frame(input string tag);
        chk({tag, "_timeout"}, int'(timed_out), 0);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_writes[%0d]", tag, i), nw[i], N_PIX);
            chk($sformatf("%s_done_count[%0d]", tag, i), nd[i], 1);
            chk($sformatf("%s_err[%0d]", tag, i), int'(err_w[i]), 0);
            chk($sformatf("%s_busy_after[%0d]", tag, i), int'(busy_w[i]), 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cap_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_busy[%0d]", i), int'(busy_w[i]), 0);
            chk($sformatf("rst_wr_en[%0d]", i), int'(we_w[i]), 0);
            chk($sformatf("rst_wr_addr[%0d]", i), int'(addr_w[i]), 0);
            chk($sformatf("rst_wr_data[%0d]", i), int'(data_w[i]), 0);
            chk($sformatf("rst_frame_done[%0d]", i), int'(done_w[i]), 0);
            chk($sformatf("rst_frame_err[%0d]", i), int'(err_w[i]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // plain capture, armed in the middle of a frame
        wait_line(7);
        for (int i = 0; i < 2; i++) chk($sformatf("idle_busy[%0d]", i), int'(busy_w[i]), 0);
        pulse_start();
        for (int i = 0; i < 2; i++) chk($sformatf("armed_busy[%0d]", i), int'(busy_w[i]), 1);
        run_frame(3 * FRAME, -1, -1);
        check_clean_frame("cap1");

        // extra cap_start during CAPTURE must be ignored
        wait_line(7);
        pulse_start();
        run_frame(3 * FRAME, 4, -1);
        check_clean_frame("cap_restart_ignored");

        // one short line inside the window
        wait_line(7);
        pulse_start();
        short_en = 1'b1;
        run_frame(3 * FRAME, -1, -1);
        short_en = 1'b0;
        chk("short_timeout", int'(timed_out), 0);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("short_err[%0d]", i), int'(err_w[i]), 1);
            chk($sformatf("short_busy[%0d]", i), int'(busy_w[i]), 0);
            chk($sformatf("short_done_count[%0d]", i), nd[i], 0);
            chk($sformatf("short_partial_writes[%0d]", i), nw[i], 2 * CAP_W);
        end

        // cap_start clears the sticky error, then reset lands mid-capture
        wait_line(7);
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("err_cleared[%0d]", i), int'(err_w[i]), 0);
            chk($sformatf("rearm_busy[%0d]", i), int'(busy_w[i]), 1);
        end
        run_frame(3 * FRAME, -1, 7);
        chk("pre_reset_timeout", int'(timed_out), 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("midrst_wr_en[%0d]", i), int'(we_w[i]), 0);
            chk($sformatf("midrst_wr_addr[%0d]", i), int'(addr_w[i]), 0);
            chk($sformatf("midrst_busy[%0d]", i), int'(busy_w[i]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(2 * FRAME, -1, -1);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("quiet_writes[%0d]", i), nw[i], 0);
            chk($sformatf("quiet_done[%0d]", i), nd[i], 0);
        end

        wait_line(7);
        pulse_start();
        run_frame(3 * FRAME, -1, -1);
        check_clean_frame("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
